// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: size/sign codes, FSM state
// encoding and small decode helpers used by the top and the extender.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (see load_store_unit.sv).
package load_store_unit_pkg;

  // Size/sign codes carried on lsu_op. Codes 011/110/111 behave as LB_SB.
  localparam logic [2:0] LB_SB = 3'b000;
  localparam logic [2:0] LH_SH = 3'b001;
  localparam logic [2:0] LW_SW = 3'b010;
  localparam logic [2:0] LBU   = 3'b100;
  localparam logic [2:0] LHU   = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERROR  = 2'd3
  } lsu_state_t;

  // Index of the final byte of an access (byte count minus one).
  function automatic logic [1:0] last_index(input logic [2:0] op);
    logic [1:0] idx;
    case (op)
      LH_SH, LHU: idx = 2'd1;
      LW_SW:      idx = 2'd3;
      default:    idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Natural-alignment test for halfword and word accesses.
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
    logic mis;
    case (op)
      LH_SH, LHU: mis = addr_lo[0];
      LW_SW:      mis = |addr_lo;
      default:    mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Little-endian byte lane select.
  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// load_extend: combinational size/sign extension of the assembled load word.
// Signed codes (LB_SB, LH_SH and the undefined codes that alias LB_SB)
// replicate the top bit of the loaded field; LBU/LHU zero-fill; LW_SW passes.
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  logic signed [7:0]  raw_b;
  logic signed [15:0] raw_h;
  logic signed [31:0] sext_b;
  logic signed [31:0] sext_h;

  assign raw_b  = raw[7:0];
  assign raw_h  = raw[15:0];
  assign sext_b = 32'(raw_b);
  assign sext_h = 32'(raw_h);

  // Select the extension mode from the size/sign code.
  always_comb begin
    ext = 32'(sext_b);
    case (op)
      LBU:     ext = {24'h0, raw[7:0]};
      LHU:     ext = {16'h0, raw[15:0]};
      LH_SH:   ext = 32'(sext_h);
      LW_SW:   ext = raw;
      default: ext = 32'(sext_b);
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte-serial load/store engine between the core and an
// 8-bit data memory. One access is captured from the core, split into 1, 2
// or 4 byte transactions (address incrementing modulo 2^32), and completed
// with a one-cycle lsu_done pulse carrying the extended load result.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// halfword/word requests are rejected through the ERROR state with lsu_err.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_op,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic [31:0] lsu_rdata,
  output logic        lsu_done,
  output logic        lsu_busy,
  output logic        lsu_err,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata
);

  lsu_state_t  state;
  lsu_state_t  state_nxt;

  // Captured request (data path, not reset: only read once state leaves IDLE).
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;
  logic [2:0]  op_p0;
  logic        we_p0;
  logic [31:0] asm_p0;

  logic [1:0]  cnt;
  logic        accept;
  logic        byte_done;
  logic        last_byte;
  logic        trap;
  logic [31:0] ext_data;

  assign accept    = (state == IDLE) && lsu_req;
  assign byte_done = (state == ACCESS) && mem_ack;
  assign last_byte = (cnt == last_index(op_p0));

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = misaligned(lsu_op, lsu_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  // State register; reset abandons any access in flight without a done pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (lsu_req) begin
          state_nxt = trap ? ERROR : ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ack && last_byte) begin
          state_nxt = DONE;
        end
      end
      DONE:  state_nxt = IDLE;
      ERROR: state_nxt = IDLE;
    endcase
  end

  // Byte counter: cleared on accept, advanced on every completed byte.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= 2'd0;
    end else if (accept) begin
      cnt <= 2'd0;
    end else if (byte_done) begin
      cnt <= cnt + 2'd1;
    end
  end

  // ---- capture stage (p0): request fields held for the whole access ----
  // Latch the request when it is accepted in IDLE.
  always_ff @(posedge clock) begin
    if (accept) begin
      addr_p0  <= lsu_addr;
      wdata_p0 <= lsu_wdata;
      op_p0    <= lsu_op;
      we_p0    <= lsu_we;
    end
  end

  // Assemble returning load bytes little-endian at the current byte slot.
  always_ff @(posedge clock) begin
    if (byte_done && !we_p0) begin
      case (cnt)
        2'd0:    asm_p0[7:0]   <= mem_rdata;
        2'd1:    asm_p0[15:8]  <= mem_rdata;
        2'd2:    asm_p0[23:16] <= mem_rdata;
        default: asm_p0[31:24] <= mem_rdata;
      endcase
    end
  end

  load_extend u_load_extend (
    .op  (op_p0),
    .raw (asm_p0),
    .ext (ext_data)
  );

  // Outputs decoded purely from state and held registers, so the memory
  // request stays stable across ack stalls and everything is 0 in IDLE.
  always_comb begin
    lsu_rdata = 32'h0;
    lsu_done  = 1'b0;
    lsu_busy  = 1'b0;
    lsu_err   = 1'b0;
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 8'h0;
    unique case (state)
      IDLE: begin
        lsu_busy = 1'b0;
      end
      ACCESS: begin
        lsu_busy  = 1'b1;
        mem_req   = 1'b1;
        mem_wr    = we_p0;
        mem_addr  = addr_p0 + {30'h0, cnt};
        mem_wdata = byte_lane(wdata_p0, cnt);
      end
      DONE: begin
        lsu_busy  = 1'b1;
        lsu_done  = 1'b1;
        lsu_rdata = we_p0 ? 32'h0 : ext_data;
      end
      ERROR: begin
        lsu_busy = 1'b1;
        lsu_done = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        lsu_err  = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a behavioural byte memory with
// programmable ack stalls, directed scenarios and a randomized run compared
// against a reference byte-array model of the expected memory image.
module tb_load_store_unit;

  logic        clock;
  logic        reset;
  logic        lsu_req;
  logic        lsu_we;
  logic [2:0]  lsu_op;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [31:0] lsu_rdata;
  logic        lsu_done;
  logic        lsu_busy;
  logic        lsu_err;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  int checks = 0;
  int errors = 0;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  load_store_unit dut (
    .clock     (clock),
    .reset     (reset),
    .lsu_req   (lsu_req),
    .lsu_we    (lsu_we),
    .lsu_op    (lsu_op),
    .lsu_addr  (lsu_addr),
    .lsu_wdata (lsu_wdata),
    .lsu_rdata (lsu_rdata),
    .lsu_done  (lsu_done),
    .lsu_busy  (lsu_busy),
    .lsu_err   (lsu_err),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- memory model ----------------
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [7:0]  wdata;
    int          cyc;
  } xfer_t;

  logic [7:0] mem     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];
  xfer_t      xlog[$];
  int cyc        = 0;
  int stall_n    = 0;
  int wait_cnt   = 0;
  int ack_budget = -1;
  bit spurious   = 1'b0;
  int stab_viol  = 0;
  bit held       = 1'b0;
  logic [31:0] h_addr;
  logic        h_wr;
  logic [7:0]  h_wdata;

  function automatic logic [7:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a[7:0] ^ 8'hA5);
  endfunction

  function automatic logic [7:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a[7:0] ^ 8'hA5);
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    mem[a]     = d;
    ref_mem[a] = d;
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // The memory decides ack at the negedge; the transfer completes at the next posedge.
  always @(negedge clock) begin
    if (mem_req === 1'b1) begin
      mem_ack   = (wait_cnt >= stall_n) && (ack_budget != 0);
      mem_rdata = rd_mem(mem_addr);
      if (held && (mem_addr !== h_addr || mem_wr !== h_wr || mem_wdata !== h_wdata))
        stab_viol++;
      if (mem_ack) begin
        if (mem_wr) mem[mem_addr] = mem_wdata;
        xlog.push_back('{addr: mem_addr, wr: mem_wr, wdata: mem_wdata, cyc: cyc});
        wait_cnt = 0;
        if (ack_budget > 0) ack_budget--;
        held = 1'b0;
      end else begin
        wait_cnt++;
        held    = 1'b1;
        h_addr  = mem_addr;
        h_wr    = mem_wr;
        h_wdata = mem_wdata;
      end
    end else begin
      mem_ack   = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = 8'($urandom_range(0, 255));
      held      = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] op);
    if (op == 3'b001 || op == 3'b101) return 2;
    if (op == 3'b010) return 4;
    return 1;
  endfunction

  function automatic bit is_signed_op(input logic [2:0] op);
    return !(op == 3'b100 || op == 3'b101 || op == 3'b010);
  endfunction

  function automatic bit is_mis(input logic [2:0] op, input logic [31:0] a);
    int n = nbytes(op);
    return (n > 1) && ((a % n) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a);
    int n = nbytes(op);
    longint v = 0;
    for (int i = 0; i < n; i++) v += longint'(rd_ref(a + 32'(i))) << (8 * i);
    if (is_signed_op(op) && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v -= (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  // ---------------- access driver ----------------
  task automatic do_access(input bit we, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input int stall,
                           output logic [31:0] rdata, output int lat,
                           output bit err, output bit ok);
    stall_n = stall;
    @(negedge clock);
    lsu_req = 1'b1; lsu_we = we; lsu_op = op; lsu_addr = addr; lsu_wdata = wdata;
    @(posedge clock);
    @(negedge clock);
    lsu_req = 1'b0; lsu_we = 1'($urandom_range(0, 1));
    lsu_addr = $urandom; lsu_wdata = $urandom; lsu_op = 3'($urandom_range(0, 7));
    ok = 1'b0; lat = 0; rdata = 32'h0; err = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) @(negedge clock);
      if (lsu_done === 1'b1) begin
        rdata = lsu_rdata; err = lsu_err; lat = k; ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; lsu_op = 3'b000;
    lsu_addr = 32'h0; lsu_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 8'h0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if ({mem_req, mem_wr, lsu_done, lsu_busy, lsu_err} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {mem_req, mem_wr, lsu_done, lsu_busy, lsu_err}); end
    checks++; if (lsu_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h expected 0", lsu_rdata); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 8'h0) begin
      errors++; $display("FAIL reset_mem_bus: got addr %h wdata %h expected 0/0", mem_addr, mem_wdata); end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_sw_directed();
    logic [31:0] rd; int lat; bit err, ok; int base;
    logic [7:0] exp_b[4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    base = xlog.size();
    do_access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, lat, err, ok);
    checks++; if (!ok || lat != 5) begin
      errors++; $display("FAIL sw_latency: got ok=%0d lat=%0d expected lat 5", ok, lat); end
    checks++; if (rd !== 32'h0) begin
      errors++; $display("FAIL sw_rdata: got %h expected 0", rd); end
    checks++; if (xlog.size() - base != 4) begin
      errors++; $display("FAIL sw_count: got %0d bytes expected 4", xlog.size() - base); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (xlog[base+i].addr !== 32'h10 + 32'(i) || xlog[base+i].wr !== 1'b1 ||
            xlog[base+i].wdata !== exp_b[i] || xlog[base+i].cyc != xlog[base].cyc + i) begin
          errors++; $display("FAIL sw_byte%0d: got addr %h wr %b data %h cyc+%0d expected addr %h wr 1 data %h cyc+%0d",
                             i, xlog[base+i].addr, xlog[base+i].wr, xlog[base+i].wdata,
                             xlog[base+i].cyc - xlog[base].cyc, 32'h10 + 32'(i), exp_b[i], i);
        end
      end
    end
    for (int i = 0; i < 4; i++) ref_mem[32'h10 + 32'(i)] = exp_b[i];
  endtask

  task automatic test_lb_sign();
    logic [31:0] rd; int lat; bit err, ok;
    poke(32'h10, 8'h80);
    do_access(1'b0, 3'b000, 32'h10, 32'h0, 0, rd, lat, err, ok);
    checks++; if (!ok || rd !== 32'hFFFFFF80 || lat != 2) begin
      errors++; $display("FAIL lb_sign: got ok=%0d rdata %h lat %0d expected FFFFFF80 lat 2", ok, rd, lat); end
    @(negedge clock);
    checks++; if (lsu_busy !== 1'b0 || lsu_done !== 1'b0) begin
      errors++; $display("FAIL lb_idle_after: got busy %b done %b expected 0 0", lsu_busy, lsu_done); end
    do_access(1'b0, 3'b100, 32'h10, 32'h0, 1, rd, lat, err, ok);
    checks++; if (!ok || rd !== 32'h00000080 || lat != 3) begin
      errors++; $display("FAIL lbu_zero: got ok=%0d rdata %h lat %0d expected 00000080 lat 3", ok, rd, lat); end
  endtask

  task automatic test_lh_stall();
    logic [31:0] rd; int lat; bit err, ok; int base;
    poke(32'h20, 8'h34); poke(32'h21, 8'h92);
    base = xlog.size(); stab_viol = 0;
    do_access(1'b0, 3'b001, 32'h20, 32'h0, 3, rd, lat, err, ok);
    checks++; if (!ok || lat != 9) begin
      errors++; $display("FAIL lh_latency: got ok=%0d lat=%0d expected 9", ok, lat); end
    checks++; if (rd !== 32'hFFFF9234) begin
      errors++; $display("FAIL lh_rdata: got %h expected FFFF9234", rd); end
    checks++; if (stab_viol != 0) begin
      errors++; $display("FAIL lh_stable: got %0d bus changes during stall expected 0", stab_viol); end
    checks++; if (xlog.size() - base != 2 || xlog[base].addr !== 32'h20 || xlog[base+1].addr !== 32'h21) begin
      errors++; $display("FAIL lh_addrs: got %0d transfers expected 2 at 20,21", xlog.size() - base); end
    stall_n = 0;
  endtask

`ifndef LSU_MISALIGN_TRAP_EN
  task automatic test_wrap();
    logic [31:0] rd, exp; int lat; bit err, ok; int base;
    logic [31:0] exp_a[4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    base = xlog.size();
    exp = model_load(3'b010, 32'hFFFFFFFE);
    do_access(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 0, rd, lat, err, ok);
    checks++; if (!ok || rd !== exp || err !== 1'b0) begin
      errors++; $display("FAIL wrap_rdata: got ok=%0d rdata %h err %b expected %h err 0", ok, rd, err, exp); end
    checks++; if (xlog.size() - base != 4) begin
      errors++; $display("FAIL wrap_count: got %0d expected 4", xlog.size() - base); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (xlog[base+i].addr !== exp_a[i]) begin
          errors++; $display("FAIL wrap_addr%0d: got %h expected %h", i, xlog[base+i].addr, exp_a[i]); end
      end
    end
  endtask
`else
  task automatic test_misalign();
    logic [31:0] rd; int lat; bit err, ok; int base;
    base = xlog.size();
    do_access(1'b0, 3'b010, 32'h13, 32'h0, 0, rd, lat, err, ok);
    checks++; if (!ok || lat != 1 || err !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL misalign_err: got ok=%0d lat %0d err %b rdata %h expected lat 1 err 1 rdata 0", ok, lat, err, rd); end
    checks++; if (xlog.size() != base) begin
      errors++; $display("FAIL misalign_nomem: got %0d transfers expected 0", xlog.size() - base); end
    @(negedge clock);
    checks++; if (lsu_busy !== 1'b0 || lsu_err !== 1'b0) begin
      errors++; $display("FAIL misalign_idle: got busy %b err %b expected 0 0", lsu_busy, lsu_err); end
  endtask
`endif

  task automatic test_reset_abort();
    int base; bit reached; bit saw_done;
    for (int i = 0; i < 4; i++) poke(32'h40 + 32'(i), 8'(8'h11 * (i + 1)));
    base = xlog.size(); ack_budget = 2; stall_n = 0; wait_cnt = 0;
    @(negedge clock);
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_op = 3'b010; lsu_addr = 32'h40; lsu_wdata = 32'hCAFEF00D;
    @(posedge clock);
    @(negedge clock); #1;
    lsu_req = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (xlog.size() - base >= 2) begin reached = 1'b1; break; end
      @(negedge clock); #1;
    end
    checks++; if (!reached) begin
      errors++; $display("FAIL abort_two_bytes: got %0d bytes expected 2", xlog.size() - base); end
    @(negedge clock); #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h42) begin
      errors++; $display("FAIL abort_third_pending: got req %b addr %h expected 1 00000042", mem_req, mem_addr); end
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock); #1;
    checks++; if (mem_req !== 1'b0 || lsu_busy !== 1'b0 || lsu_done !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got req %b busy %b done %b expected 0 0 0", mem_req, lsu_busy, lsu_done); end
    reset = 1'b1; ack_budget = -1; wait_cnt = 0;
    saw_done = 1'b0;
    repeat (6) begin @(negedge clock); if (lsu_done === 1'b1) saw_done = 1'b1; end
    checks++; if (saw_done) begin
      errors++; $display("FAIL abort_no_done: got done pulse expected none"); end
    checks++; if (mem[32'h40] !== 8'h0D || mem[32'h41] !== 8'hF0 || mem[32'h42] !== 8'h33 || mem[32'h43] !== 8'h44) begin
      errors++; $display("FAIL abort_mem: got %h %h %h %h expected 0D F0 33 44", mem[32'h40], mem[32'h41], mem[32'h42], mem[32'h43]); end
    ref_mem[32'h40] = 8'h0D; ref_mem[32'h41] = 8'hF0;
  endtask

  task automatic test_back_to_back();
    int base; int dones = 0; int c1 = 0; int c2 = 0;
    base = xlog.size(); stall_n = 0;
    @(negedge clock);
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_op = 3'b000; lsu_addr = 32'h80; lsu_wdata = 32'h5A;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      if (lsu_done === 1'b1) begin
        dones++;
        if (dones == 1) c1 = k;
        else begin c2 = k; lsu_req = 1'b0; break; end
      end
    end
    lsu_req = 1'b0;
    repeat (4) @(negedge clock);
    checks++; if (dones != 2 || c2 - c1 != 3) begin
      errors++; $display("FAIL b2b_dones: got %0d dones gap %0d expected 2 gap 3", dones, c2 - c1); end
    checks++; if (xlog.size() - base != 2) begin
      errors++; $display("FAIL b2b_writes: got %0d expected 2", xlog.size() - base); end
    ref_mem[32'h80] = 8'h5A;
  endtask

  task automatic test_random();
    logic [31:0] rd, exp_rd, addr, wdata; logic [2:0] op; bit we, err, ok, exp_err;
    int lat, exp_lat, n, stall, base;
    spurious = 1'b1;
    for (int t = 0; t < 40; t++) begin
      we    = 1'($urandom_range(0, 1));
      op    = 3'($urandom_range(0, 7));
      addr  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                          : 32'h100 + 32'($urandom_range(0, 15));
      wdata = $urandom;
      stall = $urandom_range(0, 2);
      n       = nbytes(op);
      exp_err = TRAP && is_mis(op, addr);
      exp_lat = exp_err ? 1 : n * (stall + 1) + 1;
      exp_rd  = (we || exp_err) ? 32'h0 : model_load(op, addr);
      base = xlog.size();
      do_access(we, op, addr, wdata, stall, rd, lat, err, ok);
      checks++; if (!ok || lat != exp_lat || rd !== exp_rd || err !== exp_err) begin
        errors++; $display("FAIL rand%0d: we %0d op %0d addr %h got ok=%0d lat %0d rdata %h err %b expected lat %0d rdata %h err %b",
                           t, we, op, addr, ok, lat, rd, err, exp_lat, exp_rd, exp_err); end
      checks++; if (xlog.size() - base != (exp_err ? 0 : n)) begin
        errors++; $display("FAIL rand%0d_count: got %0d expected %0d", t, xlog.size() - base, exp_err ? 0 : n); end
      if (we && !exp_err) begin
        for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
        for (int i = 0; i < n; i++) begin
          checks++; if (rd_mem(addr + 32'(i)) !== rd_ref(addr + 32'(i))) begin
            errors++; $display("FAIL rand%0d_mem%0d: got %h expected %h", t, i, rd_mem(addr + 32'(i)), rd_ref(addr + 32'(i))); end
        end
      end
    end
    spurious = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sw_directed();
    test_lb_sign();
    test_lh_stall();
`ifndef LSU_MISALIGN_TRAP_EN
    test_wrap();
`else
    test_misalign();
`endif
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
